// File: rtl/hdc_class_trainer_pkg.sv
// hdc_pkg: shared definitions for the HDC class-vector trainer.
//   - Default dimension, chunk width and counter width.
//   - Label and FSM state enums.
//   - sat_step(): one saturating +/-1 step of a signed counter.
package hdc_pkg;

   localparam int unsigned HDC_DIM   = 1024;
   localparam int unsigned HDC_W     = 64;
   localparam int unsigned HDC_CNT_W = 8;

   typedef enum logic {
      HAM  = 1'b0,
      SPAM = 1'b1
   } label_t;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      CLEAR
   } state_t;

   // Counter value is widened to int so one function serves any width below 32.
   function automatic int sat_step(input int cnt, input logic inc, input int unsigned cnt_w);
      int max_v;
      int min_v;
      max_v = (1 << (cnt_w - 1)) - 1;
      min_v = -(1 << (cnt_w - 1));
      if (inc) begin
         return (cnt >= max_v) ? max_v : cnt + 1;
      end
      return (cnt <= min_v) ? min_v : cnt - 1;
   endfunction

endpackage

// File: rtl/hdc_class_trainer_if.sv
// hdc_class_trainer_if: chunk input stream plus class-vector read port.
//   master: message source / classifier loader side
//   slave : trainer side
//   in_valid/in_ready/in_data/in_label : labelled message chunk stream
//   rd_req/rd_ready/rd_class/rd_addr   : read request
//   rd_valid/rd_data                   : registered thresholded chunk
interface hdc_class_trainer_if #(
   parameter int unsigned W  = 64,
   parameter int unsigned AW = 4
);
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          in_label;
   logic          rd_req;
   logic          rd_ready;
   logic          rd_class;
   logic [AW-1:0] rd_addr;
   logic          rd_valid;
   logic [W-1:0]  rd_data;

   modport master (
      output in_valid, in_data, in_label, rd_req, rd_class, rd_addr,
      input  in_ready, rd_ready, rd_valid, rd_data
   );

   modport slave (
      input  in_valid, in_data, in_label, rd_req, rd_class, rd_addr,
      output in_ready, rd_ready, rd_valid, rd_data
   );
endinterface

// File: rtl/hdc_class_trainer_sat_counter_row.sv
// hdc_sat_counter_row: W parallel saturating bipolar counters (combinational).
//   row_in  : current counter values
//   bits    : message bits, 1 -> +1, 0 -> -1
//   en      : apply the step; otherwise row_out = row_in
//   row_out : updated counter values
//   thr     : row_out thresholded (1 iff counter > 0)
module hdc_sat_counter_row
   import hdc_pkg::*;
#(
   parameter int unsigned W     = HDC_W,
   parameter int unsigned CNT_W = HDC_CNT_W
) (
   input  logic signed [CNT_W-1:0] row_in  [W],
   input  logic        [W-1:0]     bits,
   input  logic                    en,
   output logic signed [CNT_W-1:0] row_out [W],
   output logic        [W-1:0]     thr
);
   always_comb begin
      thr = '0;
      for (int unsigned i = 0; i < W; i++) begin
         row_out[i] = en ? CNT_W'(sat_step(int'(row_in[i]), bits[i], CNT_W)) : row_in[i];
         thr[i]     = (row_out[i] > 0);
      end
   end
endmodule

// File: rtl/hdc_class_trainer.sv
// hdc_class_trainer: bundles labelled binary message hypervectors into
// per-class saturating bipolar counters and serves thresholded chunks.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : chunk input stream and read port (slave modport)
//   clear      : one-cycle pulse, zero all counters over NCH cycles
//   msg_done   : one-cycle pulse after the last beat of a message
//   busy       : state != IDLE
// Optional feature macro HDC_TRAIN_STATS_EN adds ham_count/spam_count,
// saturating 16-bit per-class message counters cleared by reset and clear.
module hdc_class_trainer
   import hdc_pkg::*;
#(
   parameter int unsigned DIM   = HDC_DIM,
   parameter int unsigned W     = HDC_W,
   parameter int unsigned CNT_W = HDC_CNT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   hdc_class_trainer_if.slave bus,
   input  logic               clear,
   output logic               msg_done,
   output logic               busy
`ifdef HDC_TRAIN_STATS_EN
   ,
   output logic [15:0]        ham_count,
   output logic [15:0]        spam_count
`endif
);
   localparam int unsigned NCH = DIM / W;
   localparam int unsigned AW  = (NCH > 1) ? $clog2(NCH) : 1;

   state_t                  state;
   label_t                  lbl;
   logic [AW-1:0]           beat;
   logic [AW-1:0]           clr_idx;
   logic                    rd_valid_q;
   logic [W-1:0]            rd_data_q;
   logic signed [CNT_W-1:0] mem     [2][NCH][W];
   logic signed [CNT_W-1:0] row_in  [W];
   logic signed [CNT_W-1:0] row_out [W];
   logic [W-1:0]            wr_thr;
   logic [W-1:0]            rd_thr;
   logic                    accept;
   logic                    rd_fire;
   logic                    last_beat;
   label_t                  wr_class;

   assign bus.in_ready = (state != CLEAR);
   assign bus.rd_ready = (state == IDLE);
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;
   assign busy         = (state != IDLE);

   // clear outranks a simultaneous beat
   assign accept    = bus.in_valid && bus.in_ready && !clear;
   assign rd_fire   = bus.rd_req && bus.rd_ready;
   assign wr_class  = (state == IDLE) ? label_t'(bus.in_label) : lbl;
   assign last_beat = (beat == AW'(NCH - 1));

   always_comb begin
      for (int unsigned i = 0; i < W; i++) begin
         row_in[i] = mem[wr_class][beat][i];
      end
   end

   hdc_sat_counter_row #(
      .W     (W),
      .CNT_W (CNT_W)
   ) u_row (
      .row_in  (row_in),
      .bits    (bus.in_data),
      .en      (accept),
      .row_out (row_out),
      .thr     (wr_thr)
   );

   // Reads see the beat accepted in the same cycle: forward the updated row.
   always_comb begin
      rd_thr = '0;
      for (int unsigned i = 0; i < W; i++) begin
         rd_thr[i] = (mem[bus.rd_class][bus.rd_addr][i] > 0);
      end
      if (accept && (wr_class == label_t'(bus.rd_class)) && (beat == bus.rd_addr)) begin
         rd_thr = wr_thr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned c = 0; c < 2; c++) begin
            for (int unsigned r = 0; r < NCH; r++) begin
               for (int unsigned i = 0; i < W; i++) begin
                  mem[c][r][i] <= '0;
               end
            end
         end
      end else if (state == CLEAR) begin
         for (int unsigned c = 0; c < 2; c++) begin
            for (int unsigned i = 0; i < W; i++) begin
               mem[c][clr_idx][i] <= '0;
            end
         end
      end else if (accept) begin
         for (int unsigned i = 0; i < W; i++) begin
            mem[wr_class][beat][i] <= row_out[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         lbl        <= HAM;
         beat       <= '0;
         clr_idx    <= '0;
         msg_done   <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
`ifdef HDC_TRAIN_STATS_EN
         ham_count  <= '0;
         spam_count <= '0;
`endif
      end else begin
         msg_done   <= 1'b0;
         rd_valid_q <= rd_fire;
         if (rd_fire) begin
            rd_data_q <= rd_thr;
         end
         if (clear) begin
            state   <= CLEAR;
            beat    <= '0;
            clr_idx <= '0;
`ifdef HDC_TRAIN_STATS_EN
            ham_count  <= '0;
            spam_count <= '0;
`endif
         end else begin
            case (state)
               IDLE, ACCUM: begin
                  if (accept) begin
                     if (state == IDLE) begin
                        lbl <= label_t'(bus.in_label);
                     end
                     if (last_beat) begin
                        beat     <= '0;
                        state    <= IDLE;
                        msg_done <= 1'b1;
`ifdef HDC_TRAIN_STATS_EN
                        if (wr_class == HAM) begin
                           if (ham_count != '1) ham_count <= ham_count + 16'd1;
                        end else begin
                           if (spam_count != '1) spam_count <= spam_count + 16'd1;
                        end
`endif
                     end else begin
                        beat  <= beat + 1'b1;
                        state <= ACCUM;
                     end
                  end
               end
               CLEAR: begin
                  if (clr_idx == AW'(NCH - 1)) begin
                     state <= IDLE;
                  end else begin
                     clr_idx <= clr_idx + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
